dot_acc: RTL and testbench
==========================

DOT_ACC -- requirements
Module: dot_acc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand width of the upstream dot8 product stage.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: accumulator and result width; legal range DATA_WIDTH*2+3 to 48.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ena, input, 1 bit: global advance enable; low freezes all state.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data carries a valid dot8 result.
REQ-007 SHALL have port in_last, input, 1 bit: the current beat is the final term of a group.
REQ-008 SHALL have port in_data, input, DATA_WIDTH*2+3 bits: signed two's-complement dot8 result.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data, out_ovf and out_count hold a completed group.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port out_data, output, ACC_WIDTH bits: signed accumulated group sum.
REQ-013 SHALL have port out_ovf, output, 1 bit: saturation occurred within the group.
REQ-014 SHALL have port out_count, output, 16 bits: number of terms in the group.

Function
REQ-015 SHALL accept a beat in a cycle only when ena, in_valid and in_ready are all 1.
REQ-016 SHALL drive in_ready = ena and not (out_valid and not out_ready), combinationally.
REQ-017 SHALL sign-extend in_data to ACC_WIDTH before any addition.
REQ-018 SHALL use a two-state FSM: IDLE (no open group) and ACCUM (partial group held).
REQ-019 In IDLE, an accepted non-last beat SHALL load acc=in_data and cnt=1, set ovf=0, and move to ACCUM.
REQ-020 In ACCUM, an accepted non-last beat SHALL set acc=sat(acc+in_data), increment cnt, and OR the saturation event into ovf.
REQ-021 Any accepted beat with in_last=1 SHALL compute the final sum as in REQ-019/020, load out_data/out_count/out_ovf, set out_valid=1 on the next edge, clear acc, cnt and ovf, and return to IDLE.
REQ-022 Latency SHALL be one cycle from acceptance of the last beat to out_valid=1.
REQ-023 sat() SHALL clamp to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) on signed overflow; no wrap-around.
REQ-024 cnt SHALL saturate at 0xFFFF and SHALL NOT wrap.
REQ-025 out_valid SHALL clear on an edge where ena=1, out_ready=1, and no last beat is accepted.
REQ-026 If a pop and a last-beat acceptance occur in the same cycle, the new result SHALL replace the old one and out_valid SHALL remain 1 with no gap.
REQ-027 While out_valid=1 and out_ready=0, out_data, out_count and out_ovf SHALL hold stable and in_ready SHALL be 0.
REQ-028 ena=0 SHALL freeze FSM, acc, cnt, ovf and output registers; no pop SHALL occur; in_ready=0.
REQ-029 in_data and in_last SHALL be ignored when no beat is accepted.

Reset
REQ-030 Asserting rst SHALL immediately force the FSM to IDLE; acc, cnt, ovf, out_data, out_count and out_ovf to 0; and out_valid to 0.
REQ-031 Reset mid-group SHALL discard the partial sum; the first accepted beat after release SHALL open a new group.
REQ-032 After rst deasserts, in_ready SHALL equal ena.

Verification
REQ-033 Group test: inputs 5, -3, 10 (last), ena=1, out_ready=1 -> one cycle after the last beat, out_valid=1, out_data=12, out_count=3, out_ovf=0.
REQ-034 Single-beat group: in_data=-7 with in_last=1 -> out_data=-7 (0xFFFFFFF9), out_count=1.
REQ-035 Saturation test: ACC_WIDTH=19, inputs +262143 then +1 (last) -> out_data=262143, out_ovf=1; the next group reports out_ovf=0.
REQ-036 Backpressure test: out_ready=0 after a result -> in_ready=0 and outputs stable for 10 cycles; then out_ready=1 -> pop, and a last beat accepted in the same cycle gives back-to-back out_valid.
REQ-037 Freeze test: ena=0 for 3 cycles in the middle of a group with in_valid=1 -> no terms added; the final sum matches the sum with the gaps removed.
REQ-038 Reset test: rst pulsed after 2 beats of a group, then inputs 4, 4 (last) -> out_data=8, out_count=2.

Source files
------------

// File: rtl/dot_acc.sv
// rtl/dot_acc.sv - saturating group accumulator for signed dot8 results
module dot_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [DATA_WIDTH*2+2:0]   in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic                      out_ovf,
  output logic [15:0]               out_count
);

  localparam int IW = DATA_WIDTH * 2 + 3;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t                   state;
  state_t                   state_next;
  logic signed [IW-1:0]     in_s;
  logic signed [ACC_WIDTH-1:0] ext;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH:0]   sum_wide;
  logic signed [ACC_WIDTH-1:0] sum_sat;
  logic                     sat_hit;
  logic [15:0]              cnt;
  logic                     ovf;
  logic signed [ACC_WIDTH-1:0] final_sum;
  logic [15:0]              final_cnt;
  logic                     final_ovf;
  logic                     accept;

  // Sign-extend the incoming term to accumulator width
  assign in_s = in_data;
  assign ext  = ACC_WIDTH'(in_s);

  // One-bit-wider add; differing top two bits means signed overflow
  always_comb begin
    sum_wide = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};
    sat_hit  = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
    if (!sat_hit)
      sum_sat = sum_wide[ACC_WIDTH-1:0];
    else if (sum_wide[ACC_WIDTH])
      sum_sat = ACC_MIN;
    else
      sum_sat = ACC_MAX;
  end

  // Running totals including the current beat; a fresh group starts from the beat itself
  always_comb begin
    final_sum = ext;
    final_cnt = 16'd1;
    final_ovf = 1'b0;
    if (state == ACCUM) begin
      final_sum = sum_sat;
      final_cnt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
      final_ovf = ovf | sat_hit;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // FSM next state: a last beat closes the group, any other accepted beat keeps it open
  always_comb begin
    state_next = state;
    if (accept)
      state_next = in_last ? IDLE : ACCUM;
  end

  // FSM outputs: handshake; ena low or a stalled result blocks intake
  always_comb begin
    in_ready = ena & ~(out_valid & ~out_ready);
    accept   = in_ready & in_valid;
  end

  // Partial-group registers, cleared when the group is handed to the output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= final_sum;
        cnt <= final_cnt;
        ovf <= final_ovf;
      end
    end
  end

  // Output holding register; a new result may replace a popped one in the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (ena) begin
      if (accept && in_last) begin
        out_valid <= 1'b1;
        out_data  <= final_sum;
        out_count <= final_cnt;
        out_ovf   <= final_ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dot_acc.sv
// tb/tb_dot_acc.sv - self-checking bench for dot_acc at 32-bit and 19-bit accumulator widths
module tb_dot_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [18:0] in_data = '0;
  logic        out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [31:0] a_out_data;
  logic [15:0] a_out_count;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [18:0] b_out_data;
  logic [15:0] b_out_count;

  int errors = 0;
  int checks = 0;

  dot_acc #(.DATA_WIDTH(8), .ACC_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(a_in_ready), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .out_ovf(a_out_ovf),
    .out_count(a_out_count)
  );

  dot_acc #(.DATA_WIDTH(8), .ACC_WIDTH(19)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_ovf(b_out_ovf),
    .out_count(b_out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint d32;
    longint d19;
    bit     o32;
    bit     o19;
    int     cnt;
  } res_t;

  res_t   exp_q[$];
  res_t   held;
  longint s32, s19;
  bit     mo32, mo19, mopen, m_ov;
  int     mcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w, output bit hit);
    longint hi, lo;
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -hi - 1;
    hit = 1'b0;
    if (v > hi) begin hit = 1'b1; return hi; end
    if (v < lo) begin hit = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model_reset();
    s32 = 0; s19 = 0; mo32 = 0; mo19 = 0; mopen = 0; m_ov = 0; mcnt = 0;
    exp_q.delete();
    held = '{default: 0};
  endtask

  task automatic model_beat(input longint x, input bit last, output bit pushed);
    bit h;
    res_t r;
    pushed = 1'b0;
    if (!mopen) begin
      s32 = x; s19 = x; mo32 = 0; mo19 = 0; mcnt = 1;
    end else begin
      s32 = sat(s32 + x, 32, h); mo32 = mo32 | h;
      s19 = sat(s19 + x, 19, h); mo19 = mo19 | h;
      mcnt = (mcnt == 65535) ? 65535 : mcnt + 1;
    end
    if (last) begin
      r = '{d32: s32, d19: s19, o32: mo32, o19: mo19, cnt: mcnt};
      exp_q.push_back(r);
      pushed = 1'b1;
      mopen = 0;
    end else begin
      mopen = 1;
    end
  endtask

  // One clock cycle: check handshake, advance the model, then check outputs after the edge
  task automatic step();
    bit     exp_rdy, acc, pushed;
    longint x;
    #1;
    exp_rdy = ena && !(m_ov && !out_ready);
    chk("a_in_ready", 64'(a_in_ready), 64'(exp_rdy));
    chk("b_in_ready", 64'(b_in_ready), 64'(exp_rdy));
    acc    = exp_rdy && in_valid;
    pushed = 1'b0;
    x      = longint'($signed(in_data));
    if (acc) model_beat(x, in_last, pushed);
    if (ena) begin
      if (acc && in_last) m_ov = 1'b1;
      else if (out_ready) m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("a_out_valid", 64'(a_out_valid), 64'(m_ov));
    chk("b_out_valid", 64'(b_out_valid), 64'(m_ov));
    if (pushed) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        held = exp_q.pop_front();
      end
    end
    if (m_ov) begin
      chk("a_out_data", 64'(a_out_data), 64'(held.d32[31:0]));
      chk("a_out_count", 64'(a_out_count), 64'(held.cnt[15:0]));
      chk("a_out_ovf", 64'(a_out_ovf), 64'(held.o32));
      chk("b_out_data", 64'(b_out_data), 64'(held.d19[18:0]));
      chk("b_out_count", 64'(b_out_count), 64'(held.cnt[15:0]));
      chk("b_out_ovf", 64'(b_out_ovf), 64'(held.o19));
    end
  endtask

  task automatic beat(input int d, input bit last);
    in_valid = 1'b1;
    in_data  = d[18:0];
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_out_data", 64'(a_out_data), 64'd0);
    chk("rst_a_out_count", 64'(a_out_count), 64'd0);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    model_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_in_ready_eq_ena", 64'(a_in_ready), 64'(ena));
  endtask

  typedef struct {
    int d;
    bit last;
    int a_data;
    int a_cnt;
    bit a_ovf;
    int b_data;
    bit b_ovf;
  } vec_t;

  vec_t tv[$];
  logic [31:0] tmp;

  initial begin
    tv = '{
      '{5,        0, 0,       0, 0, 0,       0},
      '{-3,       0, 0,       0, 0, 0,       0},
      '{10,       1, 12,      3, 0, 12,      0},
      '{-7,       1, -7,      1, 0, -7,      0},
      '{100,      0, 0,       0, 0, 0,       0},
      '{200,      0, 0,       0, 0, 0,       0},
      '{-50,      1, 250,     3, 0, 250,     0},
      '{-262144,  0, 0,       0, 0, 0,       0},
      '{-262144,  1, -524288, 2, 0, -262144, 1},
      '{262143,   0, 0,       0, 0, 0,       0},
      '{1,        1, 262144,  2, 0, 262143,  1},
      '{3,        1, 3,       1, 0, 3,       0}
    };

    model_reset();
    #2;
    ena = 1'b1;
    do_reset();

    // Table-driven groups with continuous draining
    out_ready = 1'b1;
    for (int i = 0; i < tv.size(); i++) begin
      beat(tv[i].d, tv[i].last);
      if (tv[i].last) begin
        tmp = tv[i].a_data;
        chk("tbl_a_data", 64'(a_out_data), 64'(tmp));
        chk("tbl_a_count", 64'(a_out_count), 64'(tv[i].a_cnt));
        chk("tbl_a_ovf", 64'(a_out_ovf), 64'(tv[i].a_ovf));
        tmp = tv[i].b_data;
        chk("tbl_b_data", 64'(b_out_data), 64'(tmp[18:0]));
        chk("tbl_b_ovf", 64'(b_out_ovf), 64'(tv[i].b_ovf));
      end
    end
    step();

    // Backpressure: result held for 10 cycles, then pop with a same-cycle last beat
    beat(1, 0);
    out_ready = 1'b0;
    beat(2, 1);
    in_valid = 1'b1; in_data = 19'd99; in_last = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("bp_hold_a_data", 64'(a_out_data), 64'd3);
    out_ready = 1'b1;
    in_data   = 19'd7;
    step();
    chk("bp_b2b_valid", 64'(a_out_valid), 64'd1);
    chk("bp_b2b_data", 64'(a_out_data), 64'd7);
    in_valid = 1'b0; in_last = 1'b0;
    step();

    // Freeze: ena low mid-group with in_valid held high
    beat(1, 0);
    beat(2, 0);
    ena = 1'b0;
    in_valid = 1'b1; in_data = 19'd50; in_last = 1'b1;
    for (int i = 0; i < 3; i++) step();
    ena = 1'b1;
    beat(3, 1);
    chk("frz_a_data", 64'(a_out_data), 64'd6);
    chk("frz_a_count", 64'(a_out_count), 64'd3);
    step();

    // Reset mid-group discards the partial sum
    beat(9, 0);
    beat(9, 0);
    do_reset();
    beat(4, 0);
    beat(4, 1);
    chk("rst_grp_a_data", 64'(a_out_data), 64'd8);
    chk("rst_grp_a_count", 64'(a_out_count), 64'd2);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
